// File: rtl/lcd_mmio_ctrl_if.sv
// rtl/lcd_mmio_ctrl_if.sv - MMIO register bus between CPU window and lcd_mmio_ctrl
interface lcd_mmio_ctrl_if;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wenable;
    logic [31:0] rdata;

    modport master (output sel, addr, wdata, wenable, input rdata);
    modport slave  (input sel, addr, wdata, wenable, output rdata);
endinterface

// File: rtl/lcd_mmio_ctrl.sv
// rtl/lcd_mmio_ctrl.sv - HD44780 LCD controller: write FIFO, enable timing engine, 8/4-bit bus
// Optional LCD_SIM_PRINT_EN echoes completed data bytes to the simulator console.
module lcd_mmio_ctrl #(
    parameter int FIFO_DEPTH   = 8,
    parameter int BUS_WIDTH    = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_mmio_ctrl_if.slave       bus,
    output logic [BUS_WIDTH-1:0] lcd_data,
    output logic                 lcd_rs,
    output logic                 lcd_enable
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 16;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          lo_q, lo_d;
    logic          en_q, en_d;

    logic [AW:0]   count;
    logic          full, empty, wr, push_req, flush, clr_ovf, pop;
    logic          unused_bits;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign wr          = bus.sel & bus.wenable[0];
    assign push_req    = wr & ~bus.addr[1];
    assign flush       = wr & (bus.addr == 2'd3) & bus.wdata[0];
    assign clr_ovf     = wr & (bus.addr == 2'd3) & bus.wdata[1];
    assign unused_bits = ^{bus.wdata[31:8], bus.wenable[3:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        lo_d     = lo_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    byte_d  = mem_q[rd_ptr_q[AW-1:0]][7:0];
                    rs_d    = mem_q[rd_ptr_q[AW-1:0]][8];
                    lo_d    = 1'b0;
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CW'(PULSE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    // In nibble mode the high half is followed by a second strobe for the low half
                    if (BUS_WIDTH == 4 && !lo_q) begin
                        lo_d    = 1'b1;
                        state_d = SETUP;
                        cnt_d   = CW'(SETUP_CYCLES - 1);
                    end else begin
                        state_d = GAP;
                        cnt_d   = CW'(GAP_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        en_d = (state_d == PULSE);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A pop in the same cycle frees the slot the push needs
        if (push_req && !flush) begin
            if (!full || pop) begin
                mem_d[wr_ptr_q[AW-1:0]] = {~bus.addr[0], bus.wdata[7:0]};
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            byte_q   <= '0;
            rs_q     <= 1'b0;
            lo_q     <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            lo_q     <= lo_d;
            en_q     <= en_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.addr == 2'd2) begin
            bus.rdata[0]    = full;
            bus.rdata[1]    = empty;
            bus.rdata[2]    = (state_q != IDLE);
            bus.rdata[3]    = ovf_q;
            bus.rdata[15:8] = 8'(count);
        end
    end

    generate
        if (BUS_WIDTH == 4) begin : g_nibble
            assign lcd_data = lo_q ? byte_q[3:0] : byte_q[7:4];
        end else begin : g_byte
            assign lcd_data = byte_q;
        end
    endgenerate

    assign lcd_rs     = rs_q;
    assign lcd_enable = en_q;

`ifdef LCD_SIM_PRINT_EN
    always @(posedge clk) begin
        if (!rst && state_q == PULSE && state_d == HOLD && rs_q && (BUS_WIDTH != 4 || lo_q)) begin
            $write("%c", byte_q);
        end
    end
`else
    // Synthesis build: no console echo.
`endif
endmodule
